// File: rtl/mcycle_unit_pkg.sv
// Shared opcode and FSM state encodings for the iterative multiply/divide unit.
package mcycle_defs;

    localparam logic MC_OP_MUL = 1'b0;
    localparam logic MC_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one operand
// bit per cycle, with a combinational Busy so the core stalls in the decode cycle.
module mcycle_unit
    import mcycle_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    mc_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             op_q, op_d;
    // Addend for multiply, divisor for divide.
    logic [WIDTH-1:0] opb_q, opb_d;
    // Multiply: {hi, lo} is the 2W accumulator P. Divide: hi is R, lo is Q.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    logic [WIDTH:0]   add_a, add_b;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;
    logic [WIDTH:0]   mul_t;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    // Single shared W+1-bit adder; divide inverts the divisor and injects carry to subtract.
    always_comb begin
        if (op_q == MC_OP_DIV) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = {1'b0, opb_q};
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH + 1){1'b0}}, add_cin};
    end

    // One iteration. For divide, a carry out of the subtract means R' >= divisor;
    // the kept/restored remainder is always below the divisor, so W bits suffice.
    always_comb begin
        mul_t = '0;
        if (op_q == MC_OP_DIV) begin
            iter_hi = add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], add_sum[WIDTH+1]};
        end else begin
            mul_t   = lo_q[0] ? add_sum[WIDTH:0] : add_a;
            iter_hi = mul_t[WIDTH:1];
            iter_lo = {mul_t[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        Busy    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                Busy = Start;
                if (Start) begin
                    state_d = ST_COMPUTE;
                    count_d = '0;
                    op_d    = MCycleOp;
                    hi_d    = '0;
                    if (MCycleOp == MC_OP_DIV) begin
                        opb_d = Operand2;
                        lo_d  = Operand1;
                    end else begin
                        opb_d = Operand1;
                        lo_d  = Operand2;
                    end
                end
            end
            ST_COMPUTE: begin
                Busy    = 1'b1;
                hi_d    = iter_hi;
                lo_d    = iter_lo;
                count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = ST_DONE;
                    res1_d  = iter_lo;
                    res2_d  = iter_hi;
                end
            end
            // Start is still held by the stalled instruction here and must not retrigger.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= MC_OP_MUL;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    assign Result1 = res1_q;
    assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: vector table plus reset/back-to-back sequences.
module tb_mcycle_unit;
    import mcycle_defs::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic         MCycleOp;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*W-1:0] sb[$];

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        bit           b2b;
    } vec_t;

    vec_t tbl[9];

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full 64-bit product, or quotient/remainder with divide-by-zero convention.
    function automatic logic [2*W-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        if (op == MC_OP_MUL) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return p;
        end
        if (b == '0) return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    task automatic run_op(input string name, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input bit b2b);
        int cnt;
        int guard;
        logic [2*W-1:0] exp;
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        sb.push_back({e2, e1});
        #1;
        cnt   = 0;
        guard = 0;
        while (Busy && guard < 100) begin
            cnt++;
            guard++;
            @(negedge CLK);
            // Operands are only sampled in IDLE; scramble them while busy.
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCycleOp = ~op;
            #1;
        end
        chk({name, "_timeout"}, (guard >= 100) ? 32'd1 : 32'd0, 32'd0);
        chk({name, "_busy_cycles"}, W'(cnt), 32'd33);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk({name, "_r1"}, Result1, exp[W-1:0]);
            chk({name, "_r2"}, Result2, exp[2*W-1:W]);
        end else begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end
        Start = 1'b0;
        if (!b2b) begin
            @(negedge CLK);
            #1;
            chk({name, "_no_restart"}, {31'd0, Busy}, 32'd0);
            chk({name, "_hold_r1"}, Result1, e1);
            chk({name, "_hold_r2"}, Result2, e2);
        end
    endtask

    initial begin
        logic [2*W-1:0] m;

        tbl[0] = '{MC_OP_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0};
        tbl[1] = '{MC_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        tbl[2] = '{MC_OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tbl[3] = '{MC_OP_DIV, 32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0};
        tbl[4] = '{MC_OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0};
        tbl[5] = '{MC_OP_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 1'b1};
        tbl[6] = '{MC_OP_DIV, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0};
        m = model(MC_OP_MUL, 32'h12345678, 32'h9ABCDEF0);
        tbl[7] = '{MC_OP_MUL, 32'h12345678, 32'h9ABCDEF0, m[W-1:0], m[2*W-1:W], 1'b0};
        m = model(MC_OP_DIV, 32'hFFFFFFFF, 32'h00010003);
        tbl[8] = '{MC_OP_DIV, 32'hFFFFFFFF, 32'h00010003, m[W-1:0], m[2*W-1:W], 1'b0};

        RESET    = 1'b1;
        Start    = 1'b0;
        MCycleOp = MC_OP_MUL;
        Operand1 = '0;
        Operand2 = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_r1", Result1, 32'd0);
        chk("reset_r2", Result2, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].e1, tbl[i].e2, tbl[i].b2b);
        end

        // Abort mid-computation: count reaches 10 in the 11th COMPUTE cycle.
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = MC_OP_MUL;
        Operand1 = 32'd7;
        Operand2 = 32'd9;
        repeat (11) @(negedge CLK);
        #1;
        chk("abort_busy_before", {31'd0, Busy}, 32'd1);
        Start = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_r1", Result1, 32'd0);
        chk("abort_r2", Result2, 32'd0);
        @(negedge CLK);
        #1;
        chk("abort_stays_idle", {31'd0, Busy}, 32'd0);
        chk("abort_no_done_r1", Result1, 32'd0);

        run_op("post_reset_mul", MC_OP_MUL, 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide engine that consumes the decoder's M_Start and MCycleOp.
- Sits beside the ALU in the execute stage.
- Holds Busy high while computing so the core stalls PC and register-write.
- Results return through Result1 (low product or quotient) and Result2 (high product or remainder).
- Unsigned 32-bit operation; one operand bit per cycle.

Parameters:
WIDTH, 32, operand and result width in bits (even, >= 4)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
Start  input  1  request from decoder (M_Start); level, held by stalled instruction
MCycleOp  input  1  0 = multiply, 1 = divide; sampled with Start in IDLE
Operand1  input  WIDTH  multiplicand / dividend; sampled with Start in IDLE
Operand2  input  WIDTH  multiplier / divisor; sampled with Start in IDLE
Result1  output  WIDTH  product[WIDTH-1:0] or quotient
Result2  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder
Busy  output  1  operation in progress; core must stall while high

Behaviour:
- Clock/reset: one clock CLK; RESET is synchronous, active-high.
- Reset: state=IDLE, count=0, Result1=0, Result2=0, internal product/remainder/operand registers=0. Busy=0 after the reset edge.
- RESET mid-operation aborts immediately. Partial results are discarded, outputs go to 0 and no DONE cycle occurs.
- IDLE:
  - Busy = Start, combinational, so the stall begins in the same cycle the instruction is decoded.
  - On an edge with Start=1: latch MCycleOp and both operands, clear count, go to COMPUTE.
- COMPUTE: Busy=1. One iteration per cycle, count increments 0..WIDTH-1. After the iteration with count=WIDTH-1, load Result1/Result2 and go to DONE.
- DONE:
  - Busy=0, results valid and stable.
  - Start is ignored here: the stalled instruction is still presenting Start this cycle and must not retrigger.
  - Always go to IDLE next.
- Latency: Start rises in cycle 0, then COMPUTE runs cycles 1..WIDTH and DONE is cycle WIDTH+1. Busy is high for exactly WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: Start high in the cycle after DONE (IDLE) begins a new operation.
- Multiply (shift-add), 2*WIDTH accumulator P, initialised to {0, Operand2}:
  - Each iteration: if P[0], add Operand1 to P[2W-1:W] with carry out.
  - Then shift {carry, P} right by 1.
  - Final P gives {Result2, Result1}. The full 2W product is exact, with no overflow.
- Divide (restoring), remainder register R (WIDTH+1 bits) = 0, quotient Q = Operand1:
  - Each iteration: shift {R,Q} left by 1 and trial-subtract Operand2 from R.
  - If the result is non-negative, keep it and set Q[0]=1; otherwise restore R and set Q[0]=0.
  - Result1=Q, Result2=R[WIDTH-1:0].
- Divide by zero: no trap; the natural algorithm result is required, i.e. quotient = all ones and remainder = Operand1. Busy timing is unchanged.
- Operand changes during COMPUTE/DONE have no effect; only IDLE-sampled values are used.
- Result1/Result2 hold their last values until the next completion or RESET.

Decomposition:
- Shared header/package mcycle_defs: MC_OP_MUL=1'b0, MC_OP_DIV=1'b1; state encodings ST_IDLE=2'd0, ST_COMPUTE=2'd1, ST_DONE=2'd2.
- No sub-module required: control FSM, counter and the two datapaths live in one module. The shared adder/subtractor is a single WIDTH+1-bit add with an invert selected by the latched op.

Test Plan:
- MUL 7 x 6 (Start held until Busy falls): Busy high 33 cycles; in DONE Result1=42, Result2=0; Busy=0 in DONE; no restart in DONE.
- MUL 0xFFFFFFFF x 0xFFFFFFFF: Result2=0xFFFFFFFE, Result1=0x00000001.
- DIV 100 / 7: Result1=14, Result2=2; DIV 0x80000000 / 1: Result1=0x80000000, Result2=0.
- DIV 5 / 0: Result1=0xFFFFFFFF, Result2=5, Busy profile identical to a normal divide.
- RESET asserted in COMPUTE at count=10: next cycle IDLE, Busy=0 (Start low), Result1=Result2=0; a fresh MUL 3 x 4 then gives 12.
- Back-to-back: MUL 3 x 5 then DIV 9 / 2 with Start re-asserted in the IDLE cycle after DONE: results 15/0 then 4/1, each with Busy high 33 cycles.
